// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan controller.
//   ANODE_*  : active-low anode patterns, one per digit slot, plus all-off
//   SLOT_*   : slot index values (A, B, A+B, A-B)
//   slot_anode() : maps a slot index to its anode pattern
package seven_seg_pkg;

  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam logic [3:0] ANODE_A    = 4'b1110;
  localparam logic [3:0] ANODE_B    = 4'b1101;
  localparam logic [3:0] ANODE_SUM  = 4'b1011;
  localparam logic [3:0] ANODE_DIFF = 4'b0111;

  localparam logic [1:0] SLOT_A    = 2'd0;
  localparam logic [1:0] SLOT_B    = 2'd1;
  localparam logic [1:0] SLOT_SUM  = 2'd2;
  localparam logic [1:0] SLOT_DIFF = 2'd3;

  function automatic logic [3:0] slot_anode(input logic [1:0] slot);
    logic [3:0] pattern;
    pattern = ANODE_OFF;
    case (slot)
      SLOT_A:    pattern = ANODE_A;
      SLOT_B:    pattern = ANODE_B;
      SLOT_SUM:  pattern = ANODE_SUM;
      SLOT_DIFF: pattern = ANODE_DIFF;
      default:   pattern = ANODE_OFF;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seven_seg_scan_controller_scan_prescaler.sv
// Slot timing for the display scan.
//   clk, reset : system clock, synchronous active-high reset
//   slot_cnt   : cycle position inside the current digit slot
//   idx        : current digit slot (0..3), advances when slot_cnt wraps
//   slot_wrap  : high on the last cycle of a slot
module scan_prescaler
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] slot_cnt,
  output logic [1:0]       idx,
  output logic             slot_wrap
);

  // Equality compare so non-power-of-two dividers wrap exactly.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

  assign slot_wrap = (slot_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      idx      <= SLOT_A;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;  // 3 -> 0 wraps naturally
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Rotates an active-low anode strobe over the A, B, A+B and A-B slots,
// blanks the first GUARD_CYCLES of each slot against ghosting, and
// snapshots the operands and per-digit enables once per frame.
//   clk, reset        : system clock, synchronous active-high reset
//   A/B/AplusB/AminusB: live 4-bit operand values
//   digit_en          : per-slot enable (bit0 = A ... bit3 = A-B)
//   hold              : 1 skips the frame snapshot (display frozen)
//   anode             : active-low digit strobe
//   *_disp            : snapshotted values for the decoder
//   frame_start       : high on the first cycle of each frame
module seven_seg_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] AplusB,
  input  logic [3:0] AminusB,
  input  logic [3:0] digit_en,
  input  logic       hold,
  output logic [3:0] anode,
  output logic [3:0] A_disp,
  output logic [3:0] B_disp,
  output logic [3:0] AplusB_disp,
  output logic [3:0] AminusB_disp,
  output logic       frame_start
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] slot_cnt;
  logic [1:0]       idx;
  logic             slot_wrap;
  logic [3:0]       en_q;
  logic             frame_start_reg;
  logic             in_guard;
  logic             slot_on;

  scan_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .slot_cnt (slot_cnt),
    .idx      (idx),
    .slot_wrap(slot_wrap)
  );

  // Registered marker for slot_cnt==0 && idx==0: set by reset (counters
  // return to zero) and by the wrap out of the last slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start_reg <= 1'b1;
    end else begin
      frame_start_reg <= slot_wrap && (idx == SLOT_DIFF);
    end
  end

  assign frame_start = frame_start_reg;

  // Snapshot once per frame so a digit never changes mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      A_disp       <= '0;
      B_disp       <= '0;
      AplusB_disp  <= '0;
      AminusB_disp <= '0;
      en_q         <= '0;
    end else if (frame_start_reg && !hold) begin
      A_disp       <= A;
      B_disp       <= B;
      AplusB_disp  <= AplusB;
      AminusB_disp <= AminusB;
      en_q         <= digit_en;
    end
  end

  // With no guard interval the compare would be constant-false, so it is
  // elided entirely.
  generate
    if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      localparam logic [CNT_W-1:0] GUARD_VAL = CNT_W'(GUARD_CYCLES);
      assign in_guard = (slot_cnt < GUARD_VAL);
    end
  endgenerate

  assign slot_on = !in_guard && en_q[idx];

  // Driven from registers only, so at most one anode bit is ever low.
  always_comb begin
    anode = ANODE_OFF;
    if (slot_on) begin
      anode = slot_anode(idx);
    end
  end

endmodule
